a2d_scheduler: RTL and testbench

- Round-robin conversion sequencer for the 4-channel ADC128S A2D: left load cell, right load cell, steering pot, battery.
- Drives the existing 16-bit SPI master (wrt/done/rd_data handshake) with two transactions per channel: command, then read-back.
- Captures 12-bit results into per-channel holding registers consumed by rider-weight, steering and battery logic.
- Conversion rounds are paced by a `nxt` pulse, normally the inertial interface's valid strobe.

---
 rtl/a2d_pkg.sv | 22 ++
 rtl/a2d_timeout_ctr.sv | 29 ++
 rtl/a2d_scheduler.sv | 186 ++++++++++++++++++
 tb/tb_a2d_scheduler.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/a2d_pkg.sv
// Shared types and helpers for the A2D round-robin scheduler.
package a2d_pkg;

   typedef enum logic [2:0] {
      IDLE,
      TXN1,
      GAP,
      TXN2,
      DONE
   } a2d_state_t;

   localparam logic [1:0] IDX_LFT   = 2'd0;
   localparam logic [1:0] IDX_RGHT  = 2'd1;
   localparam logic [1:0] IDX_STEER = 2'd2;
   localparam logic [1:0] IDX_BATT  = 2'd3;

   // ADC128S command word: channel select in bits [13:11], everything else zero.
   function automatic logic [15:0] a2d_cmd(input logic [2:0] chnl);
      return {2'b00, chnl, 11'h000};
   endfunction

endpackage

// File: rtl/a2d_timeout_ctr.sv
// Clear/enable cycle counter with a terminal-count flag at TIMEOUT-1.
module a2d_timeout_ctr #(
   parameter int unsigned TIMEOUT = 4096
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_clr,
   input  logic i_en,
   output logic o_tc
);

   localparam int unsigned W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   logic [W-1:0] r_cnt;
   logic         w_tc;

   assign w_tc = (r_cnt == W'(TIMEOUT - 1));
   assign o_tc = w_tc;

   // Count enabled cycles, saturating at terminal count; clear dominates.
   always_ff @(posedge i_clk) begin
      if (i_rst || i_clr) begin
         r_cnt <= '0;
      end else if (i_en && !w_tc) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

endmodule

// File: rtl/a2d_scheduler.sv
// Round-robin ADC128S conversion sequencer: command frame, read-back frame,
// capture into per-channel result registers.
module a2d_scheduler
   import a2d_pkg::*;
#(
   parameter logic [2:0]  CH_LFT   = 3'd0,
   parameter logic [2:0]  CH_RGHT  = 3'd4,
   parameter logic [2:0]  CH_STEER = 3'd5,
   parameter logic [2:0]  CH_BATT  = 3'd6,
   parameter int unsigned TIMEOUT  = 4096
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        nxt,
   output logic        spi_wrt,
   output logic [15:0] spi_cmd,
   input  logic        spi_done,
   input  logic [15:0] spi_rd_data,
   output logic [11:0] lft_ld,
   output logic [11:0] rght_ld,
   output logic [11:0] steer_pot,
   output logic [11:0] batt,
   output logic        conv_vld,
   output logic [1:0]  chnl_idx,
   output logic        busy,
   output logic        timeout_err
);

   a2d_state_t  r_state;
   a2d_state_t  w_nxt_state;

   logic        r_pending;
   logic        r_spi_wrt;
   logic [15:0] r_spi_cmd;
   logic        r_conv_vld;
   logic        r_timeout_err;
   logic        r_busy;
   logic [1:0]  r_chnl_idx;
   logic [11:0] r_lft_ld;
   logic [11:0] r_rght_ld;
   logic [11:0] r_steer_pot;
   logic [11:0] r_batt;

   logic        w_start;
   logic        w_wrt;
   logic        w_capture;
   logic        w_advance;
   logic        w_timeout;
   logic        w_in_txn;
   logic        w_tc;
   logic [2:0]  w_chnl_sel;

   assign w_in_txn = (r_state == TXN1) || (r_state == TXN2);

   // The counter is held clear outside TXN1/TXN2, so it is zero on the
   // cycle each spi_wrt is launched and counts wait cycles from there.
   a2d_timeout_ctr #(
      .TIMEOUT (TIMEOUT)
   ) u_timeout_ctr (
      .i_clk (clk),
      .i_rst (rst),
      .i_clr (!w_in_txn),
      .i_en  (w_in_txn),
      .o_tc  (w_tc)
   );

   // Map the round-robin index onto the physical A2D channel.
   always_comb begin
      w_chnl_sel = CH_LFT;
      case (r_chnl_idx)
         IDX_LFT:   w_chnl_sel = CH_LFT;
         IDX_RGHT:  w_chnl_sel = CH_RGHT;
         IDX_STEER: w_chnl_sel = CH_STEER;
         IDX_BATT:  w_chnl_sel = CH_BATT;
         default:   w_chnl_sel = CH_LFT;
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_nxt_state;
      end
   end

   // Next-state and per-cycle action decode.
   always_comb begin
      w_nxt_state = r_state;
      w_start     = 1'b0;
      w_wrt       = 1'b0;
      w_capture   = 1'b0;
      w_advance   = 1'b0;
      w_timeout   = 1'b0;
      case (r_state)
         IDLE: begin
            if (nxt || r_pending) begin
               w_start     = 1'b1;
               w_wrt       = 1'b1;
               w_nxt_state = TXN1;
            end
         end
         TXN1: begin
            if (spi_done) begin
               w_nxt_state = GAP;
            end else if (w_tc) begin
               w_timeout   = 1'b1;
               w_nxt_state = IDLE;
            end
         end
         GAP: begin
            w_wrt       = 1'b1;
            w_nxt_state = TXN2;
         end
         TXN2: begin
            if (spi_done) begin
               w_capture   = 1'b1;
               w_nxt_state = DONE;
            end else if (w_tc) begin
               w_timeout   = 1'b1;
               w_nxt_state = IDLE;
            end
         end
         DONE: begin
            w_advance   = 1'b1;
            w_nxt_state = IDLE;
         end
         default: begin
            w_nxt_state = IDLE;
         end
      endcase
   end

   // Registered outputs, request latch, channel index and result capture.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_pending     <= 1'b0;
         r_spi_wrt     <= 1'b0;
         r_spi_cmd     <= '0;
         r_conv_vld    <= 1'b0;
         r_timeout_err <= 1'b0;
         r_busy        <= 1'b0;
         r_chnl_idx    <= IDX_LFT;
         r_lft_ld      <= '0;
         r_rght_ld     <= '0;
         r_steer_pot   <= '0;
         r_batt        <= '0;
      end else begin
         r_spi_wrt     <= w_wrt;
         r_conv_vld    <= w_capture;
         r_timeout_err <= w_timeout;
         r_busy        <= (w_nxt_state != IDLE);
         if (w_start) begin
            r_spi_cmd <= a2d_cmd(w_chnl_sel);
            r_pending <= 1'b0;
         end else if (nxt) begin
            r_pending <= 1'b1;
         end
         if (w_advance) begin
            r_chnl_idx <= r_chnl_idx + 2'd1;
         end
         if (w_capture) begin
            case (r_chnl_idx)
               IDX_LFT:   r_lft_ld    <= spi_rd_data[11:0];
               IDX_RGHT:  r_rght_ld   <= spi_rd_data[11:0];
               IDX_STEER: r_steer_pot <= spi_rd_data[11:0];
               IDX_BATT:  r_batt      <= spi_rd_data[11:0];
               default:   r_lft_ld    <= r_lft_ld;
            endcase
         end
      end
   end

   assign spi_wrt     = r_spi_wrt;
   assign spi_cmd     = r_spi_cmd;
   assign conv_vld    = r_conv_vld;
   assign timeout_err = r_timeout_err;
   assign busy        = r_busy;
   assign chnl_idx    = r_chnl_idx;
   assign lft_ld      = r_lft_ld;
   assign rght_ld     = r_rght_ld;
   assign steer_pot   = r_steer_pot;
   assign batt        = r_batt;

endmodule

// File: tb/tb_a2d_scheduler.sv
// Bench for a2d_scheduler: ADC128S/SPI stub, reference scoreboard, directed
// scenarios followed by randomized request traffic.
module tb_a2d_scheduler;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        nxt = 1'b0;
   logic        spi_wrt;
   logic [15:0] spi_cmd;
   logic        spi_done = 1'b0;
   logic [15:0] spi_rd_data = '0;
   logic [11:0] lft_ld, rght_ld, steer_pot, batt;
   logic        conv_vld;
   logic [1:0]  chnl_idx;
   logic        busy;
   logic        timeout_err;

   always #5 clk = ~clk;

   a2d_scheduler #(
      .CH_LFT   (3'd0),
      .CH_RGHT  (3'd4),
      .CH_STEER (3'd5),
      .CH_BATT  (3'd6),
      .TIMEOUT  (4096)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .nxt         (nxt),
      .spi_wrt     (spi_wrt),
      .spi_cmd     (spi_cmd),
      .spi_done    (spi_done),
      .spi_rd_data (spi_rd_data),
      .lft_ld      (lft_ld),
      .rght_ld     (rght_ld),
      .steer_pot   (steer_pot),
      .batt        (batt),
      .conv_vld    (conv_vld),
      .chnl_idx    (chnl_idx),
      .busy        (busy),
      .timeout_err (timeout_err)
   );

   int unsigned n_checks = 0;
   int unsigned n_pass   = 0;

   task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
   endtask

   // Physical channel for each round-robin slot: lft, rght, steer, batt.
   localparam logic [2:0] CH_OF [4] = '{3'd0, 3'd4, 3'd5, 3'd6};

   // Analog value each A2D channel will report.
   logic [11:0] a2d_val [8];

   // Scoreboard state.
   logic [11:0] m_reg [4];
   int unsigned m_idx = 0;
   int unsigned cyc = 0, n_conv = 0, n_to = 0, n_wrt = 0;
   int unsigned wrt_cyc = 0, done_cyc = 0, start_cyc = 0;
   bit          start_vld = 0, prev_wrt = 0;

   // Stub controls (written by the stimulus thread only).
   bit          drop2 = 0, hi_fixed = 0;
   logic [3:0]  hi_nib = 4'h0;
   int unsigned inj_req = 0, inj_ack = 0;

   // Stub state.
   int unsigned s_cnt = 0;
   bit          s_par = 0;
   logic [2:0]  s_prev_ch = 3'd0;
   logic [11:0] s_resp = '0;
   int unsigned f_len [2] = '{0, 0};

   // Observe DUT outputs and play the SPI master + ADC128S, both on the
   // falling edge. The ADC returns the conversion for the previously
   // commanded channel, so only the read-back frame carries the right data.
   always @(negedge clk) begin
      cyc++;
      if (rst) begin
         m_idx = 0;
         for (int i = 0; i < 4; i++) m_reg[i] = '0;
         start_vld = 0;
         prev_wrt  = 0;
         s_cnt     = 0;
         s_par     = 0;
      end else begin
         if (nxt && !busy && !start_vld) begin
            start_vld = 1;
            start_cyc = cyc;
         end
         if (spi_wrt) begin
            check_eq("wrt_single_cycle", prev_wrt, 0);
            check_eq("spi_cmd", spi_cmd, {2'b00, CH_OF[m_idx], 11'h000});
            check_eq("chnl_idx_at_wrt", chnl_idx, m_idx);
            check_eq("busy_at_wrt", busy, 1);
            if (s_par) check_eq("gap_cycles", cyc - done_cyc, 2);
            wrt_cyc = cyc;
            n_wrt++;
         end
         if (conv_vld) begin
            m_reg[m_idx] = a2d_val[CH_OF[m_idx]];
            check_eq("lft_ld", lft_ld, m_reg[0]);
            check_eq("rght_ld", rght_ld, m_reg[1]);
            check_eq("steer_pot", steer_pot, m_reg[2]);
            check_eq("batt", batt, m_reg[3]);
            check_eq("busy_at_conv", busy, 1);
            if (start_vld) check_eq("latency", cyc - start_cyc, 4 + f_len[0] + f_len[1]);
            start_vld = 0;
            m_idx = (m_idx + 1) % 4;
            n_conv++;
         end
         if (timeout_err) begin
            n_to++;
            start_vld = 0;
            check_eq("timeout_wait", cyc - wrt_cyc, 4096);
            check_eq("timeout_chnl_idx", chnl_idx, m_idx);
            check_eq("timeout_regs", {lft_ld, rght_ld, steer_pot, batt},
                     {m_reg[0], m_reg[1], m_reg[2], m_reg[3]});
         end
         prev_wrt = spi_wrt;
      end

      spi_done = 1'b0;
      if (inj_req != inj_ack) begin
         inj_ack++;
         spi_done    = 1'b1;
         spi_rd_data = 16'hFFFF;
      end else if (!rst) begin
         if (s_cnt != 0) begin
            s_cnt--;
            if (s_cnt == 0) begin
               spi_done    = 1'b1;
               spi_rd_data = {hi_fixed ? hi_nib : 4'($urandom), s_resp};
               done_cyc    = cyc;
            end
         end
         if (spi_wrt) begin
            s_resp      = a2d_val[s_prev_ch];
            s_prev_ch   = spi_cmd[13:11];
            f_len[s_par] = $urandom_range(1, 12);
            if (!(drop2 && s_par)) s_cnt = f_len[s_par];
            s_par = !s_par;
         end
      end
   end

   task automatic tick(input int unsigned n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic pulse_nxt();
      nxt = 1'b1;
      tick(1);
      nxt = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick(2);
      rst = 1'b0;
      tick(1);
   endtask

   task automatic wait_conv(input int unsigned target);
      int unsigned k = 0;
      while (n_conv < target && k < 500) begin
         tick(1);
         k++;
      end
      check_eq("conv_reached", n_conv, target);
   endtask

   task automatic wait_idle();
      int unsigned k = 0, quiet = 0;
      while (quiet < 4 && k < 2000) begin
         tick(1);
         quiet = busy ? 0 : quiet + 1;
         k++;
      end
      check_eq("idle_reached", busy, 0);
   endtask

   task automatic wait_wrt(input int unsigned target);
      int unsigned k = 0;
      while (n_wrt < target && k < 500) begin
         tick(1);
         k++;
      end
      check_eq("wrt_reached", n_wrt, target);
   endtask

   int unsigned base, base_to, base_wrt, expect_conv, extra;

   initial begin
      for (int i = 0; i < 8; i++) a2d_val[i] = 12'($urandom);
      tick(3);
      rst = 1'b0;
      tick(1);

      // Reset state.
      check_eq("rst_flags", {spi_wrt, conv_vld, busy, timeout_err, chnl_idx}, 0);
      check_eq("rst_cmd", spi_cmd, 16'h0000);
      check_eq("rst_regs", {lft_ld, rght_ld, steer_pot, batt}, 0);

      // Single left-channel conversion.
      a2d_val[0] = 12'h5A5;
      pulse_nxt();
      wait_conv(1);
      check_eq("t1_lft", lft_ld, 12'h5A5);
      check_eq("t1_chnl_idx", chnl_idx, 1);
      check_eq("t1_conv_one_cycle", conv_vld, 0);

      // Full round from reset: wraps back to slot 0.
      do_reset();
      base = n_conv;
      for (int i = 0; i < 4; i++) begin
         a2d_val[CH_OF[i]] = 12'($urandom);
         pulse_nxt();
         wait_conv(base + i + 1);
      end
      check_eq("t2_wrap_idx", chnl_idx, 0);

      // Burst of requests during a conversion collapses to one more.
      base = n_conv;
      pulse_nxt();
      nxt = 1'b1;
      tick(3);
      nxt = 1'b0;
      wait_idle();
      check_eq("t3_conv_count", n_conv - base, 2);

      // Read-back never completes: timeout, then pending request retries.
      base = n_conv;
      base_to = n_to;
      base_wrt = n_wrt;
      drop2 = 1;
      pulse_nxt();
      wait_wrt(base_wrt + 2);
      tick(5);
      pulse_nxt();
      begin
         int unsigned k = 0;
         while (n_to == base_to && k < 6000) begin
            tick(1);
            k++;
         end
      end
      drop2 = 0;
      check_eq("t4_timeout_seen", n_to - base_to, 1);
      check_eq("t4_no_conv", n_conv, base);
      wait_conv(base + 1);
      wait_idle();

      // Reset during read-back, then a stray spi_done.
      base = n_conv;
      base_wrt = n_wrt;
      drop2 = 1;
      pulse_nxt();
      wait_wrt(base_wrt + 2);
      tick(3);
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
      inj_req++;
      tick(4);
      drop2 = 0;
      check_eq("t5_flags", {spi_wrt, conv_vld, busy, timeout_err, chnl_idx}, 0);
      check_eq("t5_regs", {lft_ld, rght_ld, steer_pot, batt}, 0);
      check_eq("t5_no_conv", n_conv, base);

      // Battery read-back with junk in the upper nibble.
      base = n_conv;
      for (int i = 0; i < 3; i++) begin
         pulse_nxt();
         wait_conv(base + i + 1);
      end
      hi_fixed = 1;
      hi_nib = 4'hF;
      a2d_val[6] = 12'hABC;
      pulse_nxt();
      wait_conv(base + 4);
      hi_fixed = 0;
      check_eq("t6_batt", batt, 12'hABC);

      // Randomized traffic: every nxt pulse yields exactly one conversion
      // when at most one request arrives per conversion window.
      base = n_conv;
      expect_conv = 0;
      for (int it = 0; it < 30; it++) begin
         for (int i = 0; i < 8; i++) a2d_val[i] = 12'($urandom);
         tick($urandom_range(0, 5));
         pulse_nxt();
         extra = ($urandom_range(0, 2) == 0) ? 1 : 0;
         if (extra != 0) begin
            tick($urandom_range(1, 8));
            pulse_nxt();
         end
         expect_conv += 1 + extra;
         wait_idle();
      end
      check_eq("rand_conv_count", n_conv - base, expect_conv);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
